// File: rtl/data_pack_pkg.sv
// Shared definitions for the 5-byte result-pack protocol (requester and transmitter).
package data_pack_pkg;

  localparam int unsigned PACK_BYTES   = 5;
  localparam logic [7:0]  REQ_BYTE_DEF = 8'd48;
  localparam int unsigned DATA_W       = 25;
  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned PACK_W       = 8 * PACK_BYTES;
  // Field positions inside the 40-bit pack, B0 in the top byte.
  localparam int unsigned DATA_LSB     = 12;
  localparam int unsigned ADDR_LSB     = 1;

  typedef enum logic [1:0] {StIdle, StSend, StWait, StCheck} req_state_e;

  // A pack is well formed when the three pad bits of B0 and the pad bit of B4 are zero.
  function automatic logic pack_frame_ok(logic [PACK_W-1:0] pack);
    return (pack[PACK_W-1 -: 3] == 3'b000) && !pack[0];
  endfunction

endpackage

// File: rtl/data_pack_requester_if.sv
// Handshake/bus bundle between the pack requester, the UART byte FIFOs and the result consumer.
interface data_pack_requester_if;
  import data_pack_pkg::*;

  logic              req_start;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_full;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_out;
  logic              pack_valid;
  logic              frame_err;
  logic              timeout;
  logic              busy;

  modport master (
    input  req_start, tx_full, rx_data, rx_valid,
    output tx_data, tx_wr, data_out, addr_out, pack_valid, frame_err, timeout, busy
  );

  modport slave (
    output req_start, tx_full, rx_data, rx_valid,
    input  tx_data, tx_wr, data_out, addr_out, pack_valid, frame_err, timeout, busy
  );

endinterface

// File: rtl/pack_timeout_timer.sv
// Reply-byte watchdog: counts enabled cycles, pulses expire on the TIMEOUT_CYCLES-th one.
module pack_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = enable && !clear && (cnt_q == CntLast);

  // Next count: clear dominates, restart after expiry so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = expire ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/data_pack_requester.sv
// Requests a result pack over UART (sends REQ_BYTE), collects the 5 reply bytes and
// rebuilds data/addr. Optional auto-poll enabled by defining DATA_PACK_AUTO_POLL_EN.
module data_pack_requester
  import data_pack_pkg::*;
#(
  parameter logic [7:0]  REQ_BYTE       = REQ_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned POLL_PERIOD    = 1000000
) (
  input logic                  clk,
  input logic                  rst,
  data_pack_requester_if.master bus
);

  req_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pack_valid_q, pack_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              tmr_clear, tmr_en, tmr_expire;
  logic              req_fire;

`ifdef DATA_PACK_AUTO_POLL_EN
  localparam int unsigned PollW = $clog2(POLL_PERIOD) + 1;
  logic [PollW-1:0] poll_q, poll_d;
  logic             poll_fire;

  // Poll counter runs only while idle and restarts whenever a request leaves IDLE.
  always_comb begin
    poll_d    = '0;
    poll_fire = 1'b0;
    if (state_q == StIdle) begin
      if (poll_q == PollW'(POLL_PERIOD - 1)) poll_fire = 1'b1;
      else                                   poll_d    = poll_q + 1'b1;
    end
  end

  // Poll counter register.
  always_ff @(posedge clk) begin
    if (rst) poll_q <= '0;
    else     poll_q <= poll_d;
  end

  assign req_fire = bus.req_start | poll_fire;
`else
  localparam int unsigned UnusedPollPeriod = POLL_PERIOD;
  assign req_fire = bus.req_start;
`endif

  pack_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .enable(tmr_en),
    .expire(tmr_expire)
  );

  // Next-state and registered-output logic for the request/collect FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pack_d       = pack_q;
    tx_data_d    = tx_data_q;
    tx_wr_d      = 1'b0;
    data_d       = data_q;
    addr_d       = addr_q;
    pack_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    timeout_d    = 1'b0;
    busy_d       = busy_q;
    tmr_clear    = 1'b1;
    tmr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Stray rx bytes are simply dropped here.
        cnt_d = '0;
        if (req_fire) begin
          state_d = StSend;
          busy_d  = 1'b1;
        end
      end
      StSend: begin
        if (!bus.tx_full) begin
          tx_data_d = REQ_BYTE;
          tx_wr_d   = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (bus.rx_valid) begin
          pack_d = {pack_q[PACK_W-9:0], bus.rx_data};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'(PACK_BYTES - 1)) state_d = StCheck;
        end else begin
          tmr_clear = 1'b0;
          tmr_en    = 1'b1;
          if (tmr_expire) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            busy_d    = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StCheck: begin
        if (pack_frame_ok(pack_q)) begin
          data_d       = pack_q[DATA_LSB +: DATA_W];
          addr_d       = pack_q[ADDR_LSB +: ADDR_W];
          pack_valid_d = 1'b1;
        end else begin
          frame_err_d  = 1'b1;
        end
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and output registers; reset aborts any pack in progress without pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pack_q       <= '0;
      tx_data_q    <= '0;
      tx_wr_q      <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      pack_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pack_q       <= pack_d;
      tx_data_q    <= tx_data_d;
      tx_wr_q      <= tx_wr_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      pack_valid_q <= pack_valid_d;
      frame_err_q  <= frame_err_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_wr      = tx_wr_q;
  assign bus.data_out   = data_q;
  assign bus.addr_out   = addr_q;
  assign bus.pack_valid = pack_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;

endmodule
